// File: rtl/qar_gpio_pkg.sv
// qar_gpio_pkg: shared constants and elaboration helpers for the GPIO input
// conditioning path (synchroniser + debounce + edge pulses).
//   SYNC_MIN          - fewest synchroniser flops allowed per pin
//   WIDTH_MIN/MAX     - legal range for the pin count
//   DEF_PRESCALE      - suggested software default for cfg_prescale
//   DEF_THRESHOLD     - suggested software default for cfg_threshold
//   width_ok()        - WIDTH bounds check used at elaboration
package qar_gpio_pkg;

  localparam int unsigned SYNC_MIN      = 2;
  localparam int unsigned WIDTH_MIN     = 1;
  localparam int unsigned WIDTH_MAX     = 32;
  localparam int unsigned DEF_PRESCALE  = 999;
  localparam int unsigned DEF_THRESHOLD = 4;

  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/qar_debounce_bit.sv
// qar_debounce_bit: one pin of the conditioning path.
//   clk, rst_n  - clock, async active-low reset
//   pin_in      - raw asynchronous pad bit
//   tick        - shared sample tick from the top-level prescaler
//   eff_thr     - threshold already clamped to >= 1
//   bypass      - 1: level follows synchronised value every cycle
//   level_o     - conditioned level
//   rise_o      - one-cycle pulse the cycle after level_o went 0->1
//   fall_o      - one-cycle pulse the cycle after level_o went 1->0
module qar_debounce_bit
  import qar_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_MIN,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin_in,
  input  logic             tick,
  input  logic [CNT_W-1:0] eff_thr,
  input  logic             bypass,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         cnt_inc;
  logic                   lvl_q, lvl_d, lvl_prev_q;
  logic                   rise_q, fall_q;

  assign s       = sync_q[SYNC_STAGES-1];
  // One extra bit so cnt+1 cannot wrap before the compare.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (bypass) begin
      lvl_d = s;
      cnt_d = '0;
    end else if (s == lvl_q) begin
      // Input agrees with accepted level: any partial run was a glitch.
      cnt_d = '0;
    end else if (tick) begin
      // >= rather than == so a threshold lowered mid-count accepts at once.
      if (cnt_inc >= {1'b0, eff_thr}) begin
        lvl_d = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pin_in};
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      rise_q     <= lvl_q & ~lvl_prev_q;
      fall_q     <= ~lvl_q & lvl_prev_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/qar_gpio_debounce.sv
// qar_gpio_debounce: per-pin synchronise/debounce stage feeding GPIO gpio_in.
//   clk, rst_n     - clock, async active-low reset
//   pin_in         - raw pad inputs
//   cfg_prescale   - sample tick period minus 1
//   cfg_threshold  - consecutive differing ticks to accept a level (0 acts as 1)
//   cfg_bypass     - per-pin debounce bypass
//   gpio_in_o      - conditioned levels
//   rise_o/fall_o  - one-cycle edge pulses, one cycle after gpio_in_o changes
//   tick_o         - shared sample tick
module qar_gpio_debounce
  import qar_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = 16,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      pin_in,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic [CNT_W-1:0]      cfg_threshold,
  input  logic [WIDTH-1:0]      cfg_bypass,
  output logic [WIDTH-1:0]      gpio_in_o,
  output logic [WIDTH-1:0]      rise_o,
  output logic [WIDTH-1:0]      fall_o,
  output logic                  tick_o
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("qar_gpio_debounce: WIDTH out of range");
  end
  if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
    $error("qar_gpio_debounce: SYNC_STAGES too small");
  end

  logic [PRESCALE_W-1:0] pc_q;
  logic                  tick_q;
  logic [CNT_W-1:0]      eff_thr;

  // Tick is registered; the >= compare recovers immediately when
  // cfg_prescale is lowered below the running count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      tick_q <= 1'b0;
    end else if (pc_q >= cfg_prescale) begin
      pc_q   <= '0;
      tick_q <= 1'b1;
    end else begin
      pc_q   <= pc_q + PRESCALE_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o  = tick_q;
  assign eff_thr = (cfg_threshold == '0) ? CNT_W'(1) : cfg_threshold;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    qar_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_in  (pin_in[i]),
      .tick    (tick_q),
      .eff_thr (eff_thr),
      .bypass  (cfg_bypass[i]),
      .level_o (gpio_in_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
    );
  end

endmodule

// File: tb/tb_qar_gpio_debounce.sv
// Scoreboard bench: a reference model steps each clock from the rules
// (delayed pad value, tick spacing, run of differing ticks) and queues the
// expected outputs; a monitor pops one entry per cycle and compares.
module tb_qar_gpio_debounce;
  localparam int W  = 32;
  localparam int SS = 2;
  localparam int PW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  pin_in, cfg_bypass;
  logic [PW-1:0] cfg_prescale;
  logic [CW-1:0] cfg_threshold;
  logic [W-1:0]  gpio_in_o, rise_o, fall_o;
  logic          tick_o;

  qar_gpio_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .PRESCALE_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .cfg_prescale(cfg_prescale),
    .cfg_threshold(cfg_threshold), .cfg_bypass(cfg_bypass), .gpio_in_o(gpio_in_o),
    .rise_o(rise_o), .fall_o(fall_o), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         tick;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_hist[SS];  // m_hist[k] = pad value sampled k+1 edges ago
  logic [W-1:0] m_lvl, m_lvl_d, m_rise, m_fall;
  int           m_run[W];    // differing ticks seen since level last agreed
  int           m_since;     // cycles since last tick
  bit           m_tick;

  initial begin
    logic [W-1:0] s, nl;
    int eff;
    bit nt;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int k = 0; k < SS; k++) m_hist[k] = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_lvl = '0; m_lvl_d = '0; m_rise = '0; m_fall = '0;
        m_since = 0; m_tick = 0;
      end else begin
        s   = m_hist[SS-1];
        eff = (cfg_threshold == 0) ? 1 : int'(cfg_threshold);
        nl  = m_lvl;
        for (int i = 0; i < W; i++) begin
          if (cfg_bypass[i]) begin
            nl[i] = s[i]; m_run[i] = 0;
          end else if (s[i] == m_lvl[i]) begin
            m_run[i] = 0;
          end else if (m_tick) begin
            if (m_run[i] + 1 >= eff) begin nl[i] = s[i]; m_run[i] = 0; end
            else m_run[i] = m_run[i] + 1;
          end
        end
        m_rise  = m_lvl & ~m_lvl_d;
        m_fall  = ~m_lvl & m_lvl_d;
        m_lvl_d = m_lvl;
        m_lvl   = nl;
        nt      = (m_since >= int'(cfg_prescale));
        m_since = nt ? 0 : m_since + 1;
        m_tick  = nt;
        for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = pin_in;
      end
      sb_q.push_back('{m_lvl, m_rise, m_fall, m_tick});
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      n_cyc++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (!rst_n) e = '0;
        a = '{gpio_in_o, rise_o, fall_o, tick_o};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle%0d: got lvl=%h rise=%h fall=%h tick=%b expected lvl=%h rise=%h fall=%h tick=%b",
                   n_cyc, a.lvl, a.rise, a.fall, a.tick, e.lvl, e.rise, e.fall, e.tick);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst_n = 1'b0; pin_in = '1; cfg_bypass = '1; cfg_prescale = 16'd4; cfg_threshold = 4'd3;
    step(3);
    chk("reset_lvl", gpio_in_o, '0);
    chk("reset_rise", rise_o, '0);
    chk("reset_tick", W'(tick_o), '0);

    // bypass latency after reset release
    rst_n = 1'b1;
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (gpio_in_o == '1) begin k = c; break; end
    end
    chk("byp_latency", W'(k), W'(3));
    step(1); chk("rise_all", rise_o, '1);
    step(1); chk("rise_once", rise_o, '0);

    // prescaler, then lower it while pc=3
    step(12);
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (tick_o) begin k = c; break; end
    end
    chk("tick_seen", W'(k != 0), W'(1));
    step(3);
    cfg_prescale = 16'd0;
    step(1); chk("tick_after_lower", W'(tick_o), W'(1));
    step(4);

    // debounce accept latency
    cfg_bypass = '0; cfg_threshold = 4'd3; pin_in = '0;
    step(15);
    pin_in[0] = 1'b1;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (gpio_in_o[0]) begin k = c; break; end
    end
    chk("deb_latency", W'(k), W'(5));
    step(6);

    // glitch reject, then accept
    cfg_threshold = 4'd4;
    pin_in[1] = 1'b1; step(3); pin_in[1] = 1'b0; step(8);
    chk("glitch_reject", W'(gpio_in_o[1]), W'(0));
    pin_in[1] = 1'b1; step(6); pin_in[1] = 1'b0;
    chk("glitch_accept", W'(gpio_in_o[1]), W'(1));
    step(10);

    // threshold 0 acts as 1
    cfg_threshold = 4'd0;
    for (int r = 0; r < 4; r++) begin pin_in[3] = ~pin_in[3]; step(4); end

    // lower threshold 8 -> 2 with cnt=5
    cfg_threshold = 4'd8; pin_in[4] = 1'b1;
    step(7);
    chk("thr_hold", W'(gpio_in_o[4]), W'(0));
    cfg_threshold = 4'd2;
    step(1); chk("thr_lower", W'(gpio_in_o[4]), W'(1));
    step(4);

    // bypass switch mid-count
    cfg_threshold = 4'd8; pin_in[2] = 1'b1;
    step(5);
    cfg_bypass[2] = 1'b1;
    step(1); chk("byp_follow", W'(gpio_in_o[2]), W'(1));
    pin_in[2] = 1'b0; cfg_bypass[2] = 1'b0;
    step(6); chk("byp_hold", W'(gpio_in_o[2]), W'(1));
    step(10);

    // randomized traffic with occasional config changes and one reset
    cfg_threshold = 4'd2; cfg_prescale = 16'd1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) pin_in ^= ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 199) == 0) begin
        cfg_prescale  = 16'($urandom_range(0, 3));
        cfg_threshold = 4'($urandom_range(0, 6));
        cfg_bypass    = $urandom & $urandom;
      end
      rst_n = !(c == 1500 || c == 1501);
      step(1);
    end
    step(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
